// File: rtl/uart_cmd_frame_tx.sv
// uart_cmd_frame_tx
// Host-side initiator for the coprocessor's 18-byte UART command protocol.
// A command byte plus a 128-bit payload is accepted over valid/ready.
// The block then sends the frame {cmd, payload MSB byte first, cmd} as 8N1 UART, LSB first.
// Optional build macro UART_FRAME_TX_GAP_EN adds GAP_BITS idle bit-times
// after the stop bit of bytes 0..16. When the macro is absent, bytes go back-to-back.
module uart_cmd_frame_tx #(
    parameter int CLK_FREQ  = 103_340_000,
    parameter int BAUD_RATE = 9600,
    parameter int GAP_BITS  = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [7:0]   cmd_byte,
    input  logic [127:0] cmd_payload,
    output logic         tx,
    output logic         busy,
    output logic         frame_done,
    output logic [4:0]   byte_idx
);

    // CLKS_PER_BIT must be >= 4 so the bit timer is at least two bits wide.
    localparam int               CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int               TMR_W        = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_LAST     = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]       LAST_BYTE    = 5'd17;

`ifdef UART_FRAME_TX_GAP_EN
    // GAP_BITS must be >= 1 when the gap is enabled.
    localparam int               GAP_W    = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
`ifdef UART_FRAME_TX_GAP_EN
        S_GAP   = 3'd5,
`endif
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [2:0]         bit_q, bit_d;
    logic [4:0]         byte_q, byte_d;
    logic [143:0]       shreg_q, shreg_d;
    logic               tx_q, tx_d;
    logic               tmr_wrap;
    logic [7:0]         cur_byte;
`ifdef UART_FRAME_TX_GAP_EN
    logic [GAP_W-1:0]   gap_q, gap_d;
`endif

    // Next-state logic.
    // tx_d is computed from the next state, so the line register
    // changes on the same edge as the state it represents.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shreg_d  = shreg_q;
        tx_d     = 1'b1;
        cur_byte = 8'h00;
`ifdef UART_FRAME_TX_GAP_EN
        gap_d    = gap_q;
`endif
        tmr_wrap = (tmr_q == TMR_LAST);

        // The bit timer only runs while a bit (or gap bit-time) is on the line.
        if (state_q != S_IDLE && state_q != S_DONE) begin
            tmr_d = tmr_wrap ? '0 : tmr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_START;
                    tmr_d   = '0;
                    shreg_d = {cmd_byte, cmd_payload, cmd_byte};
                end
            end
            S_START: begin
                if (tmr_wrap) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (tmr_wrap) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tmr_wrap) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = S_DONE;
                        byte_d  = 5'd0;
                    end else begin
                        byte_d  = byte_q + 5'd1;
                        shreg_d = {shreg_q[135:0], 8'h00};
`ifdef UART_FRAME_TX_GAP_EN
                        state_d = S_GAP;
                        gap_d   = '0;
`else
                        state_d = S_START;
`endif
                    end
                end
            end
`ifdef UART_FRAME_TX_GAP_EN
            S_GAP: begin
                if (tmr_wrap) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_START;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line level for the next cycle. The current byte always sits in the top 8 bits.
        cur_byte = shreg_d[143:136];
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    // Control state and line register.
    // Async reset forces the line idle at once and abandons any frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 5'd0;
            tx_q    <= 1'b1;
`ifdef UART_FRAME_TX_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
`ifdef UART_FRAME_TX_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    // Frame shift register.
    // This is data only, so it has no reset; it is loaded on accept.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign tx         = tx_q;
    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign byte_idx   = byte_q;

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// Testbench for uart_cmd_frame_tx (CLKS_PER_BIT = 10).
// Stimulus pushes the expected bytes into a queue.
// A UART receiver monitor decodes tx, then pops and compares each byte.
`timescale 1ns/1ps
module tb_uart_cmd_frame_tx;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int GAP_BITS  = 2;
`ifdef UART_FRAME_TX_GAP_EN
    localparam int FRAME_LEN = 2140;
    localparam int INTER     = 25;
`else
    localparam int FRAME_LEN = 1800;
    localparam int INTER     = 5;
`endif
    localparam int WAIT_MAX  = 5000;

    typedef struct packed {
        logic [7:0] b;
        logic [4:0] idx;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_byte;
    logic [127:0] cmd_payload;
    logic         tx;
    logic         busy;
    logic         frame_done;
    logic [4:0]   byte_idx;

    uart_cmd_frame_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .GAP_BITS  (GAP_BITS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_byte    (cmd_byte),
        .cmd_payload (cmd_payload),
        .tx          (tx),
        .busy        (busy),
        .frame_done  (frame_done),
        .byte_idx    (byte_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_done = 0;
    exp_t exp_q[$];
    bit   expect_b2b = 0;
    int   t_start = 0;
    int   t_done  = 0;
    int   last_stop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [7:0] c, input logic [127:0] p);
        exp_t e;
        e.b = c; e.idx = 5'd0;
        exp_q.push_back(e);
        for (int i = 0; i < 16; i++) begin
            e.b   = p[127 - 8*i -: 8];
            e.idx = 5'(i + 1);
            exp_q.push_back(e);
        end
        e.b = c; e.idx = 5'd17;
        exp_q.push_back(e);
    endtask

    // Waits for ready with the current valid/data, steps past the accept edge, and checks the 1-clock latency.
    task automatic drive_and_accept(input bit hold);
        int w;
        w = 0;
        while (!cmd_ready && w < WAIT_MAX) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: cmd_ready still 0 after %0d cycles", w);
        end
        chk("tx_idle_before_accept", tx, 1);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        chk("tx_fall_latency", tx, 0);
        chk("ready_low_after_accept", cmd_ready, 0);
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic issue(input logic [7:0] c, input logic [127:0] p);
        push_frame(c, p);
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_byte    = c;
        cmd_payload = p;
        drive_and_accept(1'b0);
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (!frame_done && w < WAIT_MAX) begin
            @(negedge clk);
            w++;
        end
        if (!frame_done) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: frame_done not seen within %0d cycles", w);
        end else begin
            chk("ready_low_at_done", cmd_ready, 0);
            chk("busy_at_done", busy, 1);
            @(negedge clk);
            chk("ready_after_done", cmd_ready, 1);
            chk("busy_after_done", busy, 0);
        end
    endtask

    // Receiver monitor: it samples at negedges, mid-bit at clock 5 of 10, and scores each decoded byte.
    initial begin
        bit         rx_act;
        int         k;
        logic [7:0] sh;
        exp_t       e;
        rx_act = 0; k = 0; sh = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rx_act = 0;
            end else begin
                if (frame_done) begin
                    chk("frame_len", cyc - t_start, FRAME_LEN);
                    t_done = cyc;
                    n_done++;
                end
                if (!rx_act) begin
                    if (tx == 1'b0) begin
                        rx_act = 1; k = 0; sh = 8'h00;
                        if (exp_q.size() > 0) begin
                            if (exp_q[0].idx == 5'd0) begin
                                t_start = cyc;
                                if (expect_b2b) begin
                                    chk("b2b_start_gap", cyc - t_done, 2);
                                    expect_b2b = 0;
                                end
                            end else begin
                                chk("inter_byte_idle", cyc - last_stop, INTER);
                            end
                        end
                    end
                end else begin
                    k++;
                    if (k == 5) begin
                        chk("start_bit", tx, 0);
                        if (exp_q.size() > 0) chk("byte_idx", byte_idx, exp_q[0].idx);
                    end else if (k >= 15 && k <= 85 && (k % 10) == 5) begin
                        sh[(k - 15) / 10] = tx;
                    end else if (k == 95) begin
                        chk("stop_bit", tx, 1);
                        last_stop = cyc;
                        rx_act = 0;
                        if (exp_q.size() == 0) begin
                            n_chk++; n_fail++;
                            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", sh);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("byte%0d", e.idx), sh, e.b);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        logic [127:0] p_inc;
        int w;
        p_inc = 128'h000102030405060708090A0B0C0D0E0F;
        reset_n = 1'b1; cmd_valid = 1'b0; cmd_byte = 8'h00; cmd_payload = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_byte_idx", byte_idx, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: "A" with zero payload.
        issue(8'h41, 128'h0);
        wait_done();

        // 2: "C" with incrementing payload.
        repeat (4) @(negedge clk);
        issue(8'h43, p_inc);
        wait_done();

        // 3: two frames with valid held high; the second frame's data is presented mid-frame.
        repeat (4) @(negedge clk);
        push_frame(8'h41, 128'h0);
        cmd_valid = 1'b1; cmd_byte = 8'h41; cmd_payload = 128'h0;
        drive_and_accept(1'b1);
        expect_b2b = 1;
        push_frame(8'h42, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98);
        cmd_byte = 8'h42; cmd_payload = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
        wait_done();
        drive_and_accept(1'b0);
        wait_done();
        chk("b2b_checked", expect_b2b, 0);

        // 4: valid pulsed mid-frame with other data is ignored.
        repeat (4) @(negedge clk);
        issue(8'h44, 128'hFFEEDDCC_BBAA9988_77665544_33221100);
        repeat (500) @(negedge clk);
        cmd_valid = 1'b1; cmd_byte = 8'h55; cmd_payload = {4{32'hA5A5_5A5A}};
        repeat (4) begin
            @(negedge clk);
            chk("ready_while_busy", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        wait_done();

        // 5: reset during byte 5 DATA, then a full "E" frame.
        repeat (4) @(negedge clk);
        issue(8'h44, p_inc);
        w = 0;
        while (byte_idx != 5'd5 && w < WAIT_MAX) begin
            @(negedge clk);
            w++;
        end
        chk("reached_byte5", byte_idx, 5);
        repeat (25) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ready", cmd_ready, 1);
        chk("async_rst_byte_idx", byte_idx, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        issue(8'h45, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
        wait_done();

        repeat (50) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("done_pulses", n_done, 6);
        chk("idle_tx_end", tx, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_frame_tx.md
Name: uart_cmd_frame_tx

Overview:
Host-side initiator for the coprocessor's 18-byte UART command protocol. It accepts a command byte and a 128-bit payload over a valid/ready handshake and builds the frame {cmd, payload[127:0] MSB byte first, cmd}. It serialises the frame as 8N1 UART, LSB first, on a single tx line. It is used on a controller board or test fixture to drive the coprocessor's rx pin: set key ("C"), set plaintext ("D"), load ("E"), and request results ("A"/"B").

Parameters:
CLK_FREQ, 103_340_000, input clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer truncation, must be >= 4)
GAP_BITS, 2, idle bit-times inserted between bytes (used only with UART_FRAME_TX_GAP_EN)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous reset, active-low
cmd_valid  input  1  frame request
cmd_ready  output  1  block can accept a frame
cmd_byte  input  8  command character, sent as first and last byte
cmd_payload  input  128  payload, bytes [127:120] first through [7:0]
tx  output  1  UART serial out, idle high
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse after the last stop bit of byte 17
byte_idx  output  5  index (0..17) of the byte currently on the line

Behaviour:
- Reset (async assert, sync release): tx=1, cmd_ready=1, busy=0, frame_done=0, byte_idx=0, FSM=IDLE, all counters 0.
- Handshake:
  - Accept when cmd_valid && cmd_ready on a rising edge.
  - cmd_byte and cmd_payload are captured into a 144-bit shift register at the accept edge. Inputs are don't-care afterwards.
  - cmd_ready = (state==IDLE). It deasserts the cycle after accept.
- FSM states: IDLE -> START -> DATA -> STOP -> (GAP) -> START ... -> DONE -> IDLE.
  - START: tx=0 for CLKS_PER_BIT cycles. The first start bit begins the cycle after accept, so latency from accept to tx falling is 1 clock.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles. A 3-bit counter wraps 7->0 into STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte_idx<17: byte_idx increments, the shift register shifts by 8, and the FSM goes to GAP (if the feature is enabled) or START.
    - If byte_idx==17: go to DONE.
  - DONE: lasts one cycle. frame_done=1, byte_idx returns to 0, then IDLE. cmd_ready rises the cycle after frame_done.
- Back-to-back frames: a frame request held valid during DONE is accepted in the following IDLE cycle. The minimum inter-frame idle is 2 clocks, and no tx glitch is allowed.
- busy=1 from the cycle after accept through the DONE cycle inclusive.
- Bit timer: counts 0..CLKS_PER_BIT-1, then wraps. Width is $clog2(CLKS_PER_BIT). The first and last bit of each frame are exactly CLKS_PER_BIT long.
- Frame length without gap: 18*10*CLKS_PER_BIT cycles from the tx falling edge to frame_done.
- cmd_valid while busy is ignored: no queuing and no corruption of the in-flight frame.
- Reset mid-frame: tx goes to 1 immediately (async) and the frame is abandoned. The downstream receiver is responsible for resynchronising.
- tx is driven from a register; there is no combinational path from the inputs.

Optional Feature:
- Macro: UART_FRAME_TX_GAP_EN.
- Defined: a GAP state is inserted after the stop bit of bytes 0..16. tx=1 for GAP_BITS*CLKS_PER_BIT cycles. There is no gap after byte 17. Frame length = (180 + 17*GAP_BITS)*CLKS_PER_BIT cycles.
- Undefined: there is no GAP state, the GAP_BITS parameter is unused, and bytes go back-to-back.

Test Plan (CLK_FREQ=1_000_000, BAUD_RATE=100_000, CLKS_PER_BIT=10):
1. Reset, then cmd_byte="A" (0x41), payload=0, pulse valid:
   - tx falls 1 clk after accept.
   - Decoded bytes: 0x41, sixteen 0x00, 0x41.
   - frame_done exactly 1800 clks after the first falling edge.
2. cmd "C", payload 0x000102..0F:
   - Receiver model sees 0x43, 0x00, 0x01 ... 0x0F, 0x43.
   - byte_idx steps 0..17.
   - Each bit is sampled mid-period at clk 5 of 10.
3. Two frames with valid held high:
   - Second start bit begins 2 clks after the first frame_done.
   - tx stays high between frames and both frames decode correctly.
4. Valid pulsed with a different payload mid-frame:
   - Ignored, and the in-flight frame is unchanged.
   - cmd_ready stays 0 until after frame_done.
5. reset_n asserted during byte 5 DATA:
   - tx=1, busy=0, and cmd_ready=1 asynchronously.
   - After release, a new "E" frame transmits fully and correctly.
6. With UART_FRAME_TX_GAP_EN and GAP_BITS=2:
   - 20-clk idle between stop bit and next start bit, none after byte 17.
   - frame_done at 2140 clks.
